pmem_arbiter: RTL and testbench

Two-client arbiter that sits directly upstream of the line-granular physical memory. It merges instruction-cache and data-cache line requests onto the single 128-bit memory port. It serialises accesses and holds each request stable until memory responds. It then returns one-cycle responses to the granted client. Round-robin on conflict prevents either cache from starving the other.

---
 rtl/pmem_arbiter_pkg.sv | 25 ++
 rtl/pmem_arbiter_control.sv | 77 +++++++
 rtl/pmem_arbiter.sv | 108 ++++++++++
 tb/tb_pmem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared LC-3b types used by the physical-memory arbiter.
//   lc3b_word    : 16-bit machine word / byte address
//   lc3b_c_line  : 128-bit cache line
//   arb_state_t  : arbiter FSM states
//   arb_owner_t  : which cache currently owns the memory port
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_c_line;

    // Byte-offset bits within a 16-byte line.
    localparam int unsigned LINE_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE    = 2'd1,
        COMPLETE = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/pmem_arbiter_control.sv
// Arbiter control: three-state FSM, round-robin last-grant tracking and the
// grant / load-enable decode used by the datapath in pmem_arbiter.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   icache_req/dcache_req: client is requesting (read | write)
//   pmem_resp            : memory completion
//   state                : current FSM state
//   load_req             : capture the granted client's request this cycle
//   grant                : client selected by arbitration (valid with load_req)
//   load_line            : memory read data valid this cycle
module pmem_arbiter_control
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       icache_req,
    input  logic       dcache_req,
    input  logic       pmem_resp,
    output arb_state_t state,
    output logic       load_req,
    output arb_owner_t grant,
    output logic       load_line
);

    arb_state_t state_q, state_d;
    arb_owner_t last_grant_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= ARB_I;
        end else begin
            state_q <= state_d;
            if (load_req) begin
                last_grant_q <= grant;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        load_req  = 1'b0;
        load_line = 1'b0;
        grant     = ARB_I;

        // On conflict the client not granted last wins.
        if (icache_req && dcache_req) begin
            grant = (last_grant_q == ARB_I) ? ARB_D : ARB_I;
        end else if (dcache_req) begin
            grant = ARB_D;
        end

        unique case (state_q)
            IDLE: begin
                if (icache_req || dcache_req) begin
                    load_req = 1'b1;
                    state_d  = SERVE;
                end
            end
            SERVE: begin
                if (pmem_resp) begin
                    load_line = 1'b1;
                    state_d   = COMPLETE;
                end
            end
            COMPLETE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/pmem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter in front of the line-granular
// physical memory. Serialises accesses, holds the captured request on the
// memory port until pmem_resp, then pulses a one-cycle resp to the owner.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   icache_* / dcache_*              : client request strobes, address, wdata,
//                                      resp pulse and read line
//   pmem_read/pmem_write             : memory strobes
//   pmem_address                     : line-aligned address
//   pmem_wdata / pmem_rdata          : write / read line
//   pmem_resp                        : memory done
module pmem_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  icache_read,
    input  logic                  icache_write,
    input  logic [ADDR_WIDTH-1:0] icache_address,
    input  logic [LINE_WIDTH-1:0] icache_wdata,
    output logic                  icache_resp,
    output logic [LINE_WIDTH-1:0] icache_rdata,

    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_WIDTH-1:0] dcache_address,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic                  dcache_resp,
    output logic [LINE_WIDTH-1:0] dcache_rdata,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [LINE_WIDTH-1:0] pmem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
        {{(ADDR_WIDTH - LINE_OFFSET_BITS){1'b1}}, {LINE_OFFSET_BITS{1'b0}}};

    arb_state_t state;
    arb_owner_t grant;
    logic       load_req;
    logic       load_line;

    logic                  op_write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] line_q;
    arb_owner_t            owner_q;

    pmem_arbiter_control u_control (
        .clk        (clk),
        .reset      (reset),
        .icache_req (icache_read | icache_write),
        .dcache_req (dcache_read | dcache_write),
        .pmem_resp  (pmem_resp),
        .state      (state),
        .load_req   (load_req),
        .grant      (grant),
        .load_line  (load_line)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            line_q     <= '0;
            owner_q    <= ARB_I;
        end else begin
            if (load_req) begin
                owner_q <= grant;
                // Write wins when a client raises both strobes.
                if (grant == ARB_D) begin
                    op_write_q <= dcache_write;
                    addr_q     <= dcache_address & ADDR_MASK;
                    wdata_q    <= dcache_wdata;
                end else begin
                    op_write_q <= icache_write;
                    addr_q     <= icache_address & ADDR_MASK;
                    wdata_q    <= icache_wdata;
                end
            end
            if (load_line && !op_write_q) begin
                line_q <= pmem_rdata;
            end
        end
    end

    always_comb begin
        pmem_read    = (state == SERVE) && !op_write_q;
        pmem_write   = (state == SERVE) && op_write_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        icache_resp  = (state == COMPLETE) && (owner_q == ARB_I);
        dcache_resp  = (state == COMPLETE) && (owner_q == ARB_D);
        // Both clients see the shared line; each qualifies it with its own resp.
        icache_rdata = line_q;
        dcache_rdata = line_q;
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          icache_read, icache_write, icache_resp;
    logic [AW-1:0] icache_address;
    logic [LW-1:0] icache_wdata, icache_rdata;
    logic          dcache_read, dcache_write, dcache_resp;
    logic [AW-1:0] dcache_address;
    logic [LW-1:0] dcache_wdata, dcache_rdata;
    logic          pmem_read, pmem_write, pmem_resp;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata, pmem_rdata;

    always #5 clk = ~clk;

    pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk            (clk),
        .reset          (reset),
        .icache_read    (icache_read),
        .icache_write   (icache_write),
        .icache_address (icache_address),
        .icache_wdata   (icache_wdata),
        .icache_resp    (icache_resp),
        .icache_rdata   (icache_rdata),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_resp    (dcache_resp),
        .dcache_rdata   (dcache_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_resp      (pmem_resp),
        .pmem_rdata     (pmem_rdata)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [LW-1:0] init_line(input int idx);
        logic [15:0] w;
        w = idx[15:0];
        if (idx == 32'h123) return {32{4'hA}};
        return {8{w}};
    endfunction

    // ---------------- memory model: responds after mem_lat wait cycles ----------------
    logic [LW-1:0] mem [4096];
    bit            mem_ready = 1'b0;
    int            mem_lat   = 0;
    int            mem_cnt   = 0;

    assign pmem_resp  = (pmem_read | pmem_write) && (mem_cnt >= mem_lat);
    assign pmem_rdata = pmem_read ? mem[pmem_address[15:4]] : '0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_line(i);
            mem_ready <= 1'b1;
        end else if (pmem_write && pmem_resp) begin
            mem[pmem_address[15:4]] <= pmem_wdata;
        end
        if ((pmem_read | pmem_write) && !pmem_resp) mem_cnt <= mem_cnt + 1;
        else mem_cnt <= 0;
    end

    // ---------------- transaction-level reference / scoreboard ----------------
    logic [LW-1:0] ref_mem [4096];
    bit            sb_last, sb_busy, sb_owner, sb_wr;
    logic [AW-1:0] sb_addr;
    logic [LW-1:0] sb_wdata;
    int            sb_rise, cyc;
    bit            p_strobe, p_ireq, p_dreq, p_iwr, p_dwr;
    logic [AW-1:0] p_iaddr, p_daddr;
    logic [LW-1:0] p_iwd, p_dwd;
    bit            resp_log[$];

    task automatic sb_step();
        bit strobe, owner;
        int idx;
        cyc++;
        if (reset) begin
            sb_last  = 1'b0;   // I granted last -> first conflict to D
            sb_busy  = 1'b0;
            p_strobe = 1'b0;
            p_ireq   = 1'b0;
            p_dreq   = 1'b0;
            return;
        end
        strobe = pmem_read | pmem_write;
        if (strobe && !p_strobe) begin
            chk("sb_req_pending", {127'b0, p_ireq | p_dreq}, 1);
            owner    = (p_ireq && p_dreq) ? !sb_last : p_dreq;
            sb_wr    = owner ? p_dwr : p_iwr;
            sb_addr  = (owner ? p_daddr : p_iaddr) & 16'hFFF0;
            sb_wdata = owner ? p_dwd : p_iwd;
            chk("sb_addr", pmem_address, sb_addr);
            chk("sb_op_write", pmem_write, sb_wr);
            chk("sb_op_read", pmem_read, !sb_wr);
            if (sb_wr) chk("sb_wdata", pmem_wdata, sb_wdata);
            sb_owner = owner;
            sb_last  = owner;
            sb_busy  = 1'b1;
            sb_rise  = cyc;
        end else if (strobe) begin
            chk("sb_addr_stable", pmem_address, sb_addr);
            chk("sb_op_stable", pmem_write, sb_wr);
        end
        if (icache_resp || dcache_resp) begin
            chk("sb_resp_expected", sb_busy, 1);
            chk("sb_resp_owner", {dcache_resp, icache_resp}, sb_owner ? 2'b10 : 2'b01);
            chk("sb_resp_latency", cyc - sb_rise, mem_lat + 1);
            chk("sb_strobe_low", strobe, 0);
            idx = int'(sb_addr[15:4]);
            if (sb_wr) ref_mem[idx] = sb_wdata;
            else chk("sb_rdata", sb_owner ? dcache_rdata : icache_rdata, ref_mem[idx]);
            resp_log.push_back(dcache_resp);
            sb_busy = 1'b0;
        end
        p_strobe = strobe;
        p_ireq   = icache_read | icache_write;
        p_dreq   = dcache_read | dcache_write;
        p_iwr    = icache_write;
        p_dwr    = dcache_write;
        p_iaddr  = icache_address;
        p_daddr  = dcache_address;
        p_iwd    = icache_wdata;
        p_dwd    = dcache_wdata;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_line(i);
        forever begin
            @(negedge clk);
            sb_step();
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // ---------------- client drivers ----------------
    task automatic set_req(input bit is_d, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [LW-1:0] wd);
        if (is_d) begin
            dcache_read = rd; dcache_write = wr; dcache_address = a; dcache_wdata = wd;
        end else begin
            icache_read = rd; icache_write = wr; icache_address = a; icache_wdata = wd;
        end
    endtask

    task automatic drop_req(input bit is_d);
        if (is_d) begin dcache_read = 1'b0; dcache_write = 1'b0; end
        else begin icache_read = 1'b0; icache_write = 1'b0; end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drop_req(1'b0);
        drop_req(1'b1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic client(input bit is_d, input int n, input int max_gap);
        for (int k = 0; k < n; k++) begin
            int gap, t, op;
            logic [AW-1:0] a;
            logic [LW-1:0] wd;
            bit seen;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin @(posedge clk); #1; end
            op = int'($urandom_range(0, 2));      // 0 read, 1 write, 2 both
            a  = 16'h0100 + 16'($urandom_range(0, 7) * 16) + 16'($urandom_range(0, 15));
            wd = {$urandom(), $urandom(), $urandom(), $urandom()};
            set_req(is_d, op != 1, op != 0, a, wd);
            seen = 1'b0;
            t    = 0;
            while (!seen && t < 300) begin
                @(negedge clk);
                t++;
                seen = is_d ? dcache_resp : icache_resp;
            end
            chk(is_d ? "client_d_resp_seen" : "client_i_resp_seen", seen, 1);
            @(posedge clk); #1;
            drop_req(is_d);
        end
    endtask

    // ---------------- single-access vectors ----------------
    typedef struct {
        bit            is_d;
        bit            rd;
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        int            lat;
        logic [AW-1:0] exp_addr;
        bit            exp_wr;
        logic [LW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    initial begin
        reset = 1'b1;
        icache_read = 0; icache_write = 0; icache_address = '0; icache_wdata = '0;
        dcache_read = 0; dcache_write = 0; dcache_address = '0; dcache_wdata = '0;

        vecs[0] = '{0, 1, 0, 16'h1234, '0, 0, 16'h1230, 0, {32{4'hA}}};
        vecs[1] = '{1, 1, 0, 16'h0456, '0, 5, 16'h0450, 0, {8{16'h0045}}};
        vecs[2] = '{0, 0, 1, 16'h2008, {4{32'hC0FFEE11}}, 2, 16'h2000, 1, '0};
        vecs[3] = '{1, 1, 1, 16'h3FFF, {4{32'h12345678}}, 0, 16'h3FF0, 1, '0};
        vecs[4] = '{0, 1, 0, 16'h200C, '0, 1, 16'h2000, 0, {4{32'hC0FFEE11}}};

        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        do_reset();
        @(negedge clk);
        chk("rst_icache_resp", icache_resp, 0);
        chk("rst_dcache_resp", dcache_resp, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        chk("rst_rdata", icache_rdata, 0);

        for (int v = 0; v < 5; v++) begin
            int resp_cyc, own_cnt, oth_cnt, strobe_cyc;
            bit dropped, own;
            logic [LW-1:0] rd_seen;
            @(posedge clk);
            do_reset();
            mem_lat = vecs[v].lat;
            set_req(vecs[v].is_d, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
            resp_cyc = -1; own_cnt = 0; oth_cnt = 0; strobe_cyc = 0; dropped = 0;
            rd_seen = '0;
            for (int c = 0; c <= vecs[v].lat + 5; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    chk("vec_addr", pmem_address, vecs[v].exp_addr);
                    chk("vec_pmem_write", pmem_write, vecs[v].exp_wr);
                    chk("vec_pmem_read", pmem_read, !vecs[v].exp_wr);
                end
                if (pmem_read || pmem_write) strobe_cyc++;
                own = vecs[v].is_d ? dcache_resp : icache_resp;
                if (own) begin
                    own_cnt++;
                    resp_cyc = c;
                    rd_seen  = vecs[v].is_d ? dcache_rdata : icache_rdata;
                end
                if (vecs[v].is_d ? icache_resp : dcache_resp) oth_cnt++;
                if (own && !dropped) begin
                    @(posedge clk); #1;
                    drop_req(vecs[v].is_d);
                    dropped = 1;
                end
            end
            chk("vec_resp_cycle", resp_cyc, vecs[v].lat + 2);
            chk("vec_resp_once", own_cnt, 1);
            chk("vec_other_resp", oth_cnt, 0);
            chk("vec_strobe_cycles", strobe_cyc, vecs[v].lat + 1);
            if (!vecs[v].exp_wr) chk("vec_rdata", rd_seen, vecs[v].exp_rdata);
        end

        // Reset in the middle of a D access.
        @(posedge clk);
        do_reset();
        mem_lat = 20;
        set_req(1, 1, 0, 16'h0500, '0);
        repeat (3) @(negedge clk);
        chk("mid_serve_read", pmem_read, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        drop_req(1);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_pmem_read", pmem_read, 0);
        chk("mid_rst_resp", {dcache_resp, icache_resp}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_strobe", {pmem_read, pmem_write}, 0);
            chk("post_rst_resp", {dcache_resp, icache_resp}, 0);
        end
        mem_lat = 0;

        // Conflict after reset: D first, then I; six cycles total.
        @(posedge clk);
        do_reset();
        set_req(0, 1, 0, 16'h0040, '0);
        set_req(1, 0, 1, 16'h0080, {4{32'hDEADBEEF}});
        begin
            int icnt, dcnt;
            bit di, dd;
            icnt = 0; dcnt = 0; di = 0; dd = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    chk("cf_d_write", pmem_write, 1);
                    chk("cf_d_addr", pmem_address, 16'h0080);
                    chk("cf_d_wdata", pmem_wdata, {4{32'hDEADBEEF}});
                end
                if (c == 2) chk("cf_d_resp", {dcache_resp, icache_resp}, 2'b10);
                if (c == 3) chk("cf_gap_idle", {pmem_read, pmem_write}, 0);
                if (c == 4) begin
                    chk("cf_i_read", pmem_read, 1);
                    chk("cf_i_addr", pmem_address, 16'h0040);
                end
                if (c == 5) begin
                    chk("cf_i_resp", {dcache_resp, icache_resp}, 2'b01);
                    chk("cf_i_rdata", icache_rdata, {8{16'h0004}});
                end
                if (icache_resp) icnt++;
                if (dcache_resp) dcnt++;
                if (icache_resp && !di) begin @(posedge clk); #1; drop_req(0); di = 1; end
                if (dcache_resp && !dd) begin @(posedge clk); #1; drop_req(1); dd = 1; end
            end
            chk("cf_i_resp_count", icnt, 1);
            chk("cf_d_resp_count", dcnt, 1);
        end

        // Continuous conflict: grants must alternate D, I, D, I, ...
        mem_lat = 1;
        resp_log.delete();
        @(posedge clk); #1;
        fork
            client(0, 4, 0);
            client(1, 4, 0);
        join
        chk("rr_count", resp_log.size(), 8);
        for (int k = 0; k < resp_log.size() && k < 8; k++)
            chk($sformatf("rr_order_%0d", k), resp_log[k], (k % 2 == 0) ? 1 : 0);

        // Randomised traffic checked by the scoreboard.
        for (int ph = 0; ph < 3; ph++) begin
            mem_lat = int'($urandom_range(0, 3));
            @(posedge clk); #1;
            fork
                client(0, 15, 4);
                client(1, 15, 4);
            join
            repeat (3) @(posedge clk);
            #1;
        end

        @(negedge clk);
        chk("final_idle", {pmem_read, pmem_write, icache_resp, dcache_resp}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
